nco_sweep_ctrl: RTL and testbench
=================================

Name: nco_sweep_ctrl

Overview:
Frequency-sweep scheduler that drives the NCO phase-increment (freq_step) input. It steps the tuning word from a start value to a stop value by a fixed increment, holding each tone for a programmable dwell. Tone changes can be deferred to the NCO phase wrap so the DAC waveform stays phase-continuous. Sits between board controls (keys/switches) and the NCO; the NCO consumes freq_step_o directly.

Parameters:
FW, 32, tuning-word width (matches NCO phase accumulator)
DW, 16, dwell counter width
ALIGN_WRAP, 1, 1 = apply tone changes only on wrap_i; 0 = apply immediately

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
start_i  in  1  asynchronous level (key); rising edge starts a sweep
abort_i  in  1  synchronous; stops the sweep, output forced to 0
f_start_i  in  FW  first tuning word
f_stop_i  in  FW  last tuning word
f_incr_i  in  FW  tuning-word increment per step
dwell_i  in  DW  cycles per tone, minus 1
wrap_i  in  1  one-cycle NCO phase-wrap pulse (sys_clk domain)
freq_step_o  out  FW  tuning word to the NCO
freq_vld_o  out  1  one-cycle pulse whenever freq_step_o changes
busy_o  out  1  sweep in progress
done_o  out  1  sweep completed; level until next start/abort
err_o  out  1  bad configuration; sticky until the next accepted start

Behaviour:
- Reset and clocking: reset is sys_rst_n, asynchronous, active-low; clock is sys_clk. Under reset, all outputs are 0, the FSM is IDLE and the synchronizer flops are 0.
- Start input: start_i passes through a 2-FF synchronizer, then a rising-edge detector. If start_i is first sampled high at edge N, the start event is seen at edge N+2.
- Start acceptance: a start event is accepted only in IDLE or DONE; it is ignored otherwise. On acceptance, f_start/f_stop/f_incr/dwell are latched, and later input changes have no effect until the next start.
- Config check on accept: f_incr==0 or f_start>f_stop -> err_o=1, stay/return to IDLE, freq_step_o unchanged. Otherwise err_o=0 and the FSM moves to LOAD.
- FSM states: IDLE, LOAD, DWELL, ALIGN, DONE.
- LOAD: freq_step_o<=f_start and freq_vld_o=1. The dwell counter is loaded with dwell and the FSM goes to DWELL. freq_step_o updates at edge N+4 after start_i is first sampled high.
- DWELL:
  - Counter decrements each cycle. At 0 the FSM goes to ALIGN, so each tone lasts dwell+1 cycles in DWELL.
  - If cur==f_stop, the FSM goes to DONE instead of ALIGN.
- ALIGN:
  - Computes next=min(cur+f_incr, f_stop) using an FW+1-bit sum, so an overflow of cur+f_incr saturates to f_stop.
  - ALIGN_WRAP=1: next is applied on the first cycle wrap_i=1, including wrap_i high on ALIGN entry. If cur==0 (the NCO never wraps), next is applied immediately.
  - ALIGN_WRAP=0: next is applied on the cycle after entry.
  - Applying next sets freq_vld_o=1, reloads the dwell counter and moves to DWELL.
- DONE: done_o=1 and busy_o=0. freq_step_o holds f_stop.
- busy_o: 1 in LOAD/DWELL/ALIGN.
- Final tone: the last tone is always exactly f_stop.
- Degenerate sweep: f_start==f_stop gives one tone for dwell+1 cycles, then DONE.
- Abort:
  - abort_i in any state -> IDLE next edge, freq_step_o=0, busy_o=0, done_o=0.
  - freq_vld_o=1 only if freq_step_o was nonzero.
  - abort_i has priority over a same-cycle start event or wrap_i.
- Reset mid-sweep: immediate return to the reset state; no partial-step output.

Optional Feature:
NCO_SWEEP_BIDIR_EN
- Defined: triangle sweep. On reaching f_stop the FSM continues downward, next=max(cur-f_incr, f_start) with underflow saturating to f_start. On reaching f_start it goes upward again, indefinitely. DONE is never entered and done_o stays 0; only abort_i or reset ends the sweep. An internal direction bit resets to "up".
- Undefined: single upward sweep ending in DONE, exactly as in Behaviour.

Test Plan:
- Basic sweep, ALIGN_WRAP=0, f_start=0x100, f_stop=0x400, f_incr=0x100, dwell=3. Start -> freq_step_o sequence 0x100, 0x200, 0x300, 0x400. Each value is held 5 cycles (4 DWELL + 1 ALIGN), with four freq_vld_o pulses, then done_o=1 and freq_step_o=0x400.
- Saturation: f_start=0xFFFFFF00, f_stop=0xFFFFFFFF, f_incr=0x200 -> second tone is exactly 0xFFFFFFFF (no wrap to 0x100), then DONE.
- Wrap alignment, ALIGN_WRAP=1: hold wrap_i low for 50 cycles in ALIGN -> freq_step_o is unchanged. Pulse wrap_i -> freq_step_o updates on that edge with freq_vld_o=1. Also f_start=0 -> first step is taken without any wrap_i.
- Errors and ignored starts: f_incr=0 -> err_o=1, busy_o=0, freq_step_o stays 0. A valid start then clears err_o. A second start pulse mid-sweep is ignored, with no restart of the sequence.
- Abort priority: assert abort_i in DWELL together with a start edge -> next edge IDLE, freq_step_o=0, freq_vld_o=1, busy_o=0. Apply reset mid-ALIGN -> all outputs 0 asynchronously.
- NCO_SWEEP_BIDIR_EN, f_start=1, f_stop=3, f_incr=1, dwell=0 -> sequence 1, 2, 3, 2, 1, 2, 3… and done_o never asserts.

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps the NCO tuning word from f_start to f_stop, holding each tone for dwell+1 cycles.
// Defining NCO_SWEEP_BIDIR_EN makes the sweep a continuous triangle, f_start..f_stop..f_start.
module nco_sweep_ctrl #(
    parameter int FW         = 32,
    parameter int DW         = 16,
    parameter int ALIGN_WRAP = 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [FW-1:0] f_start_i,
    input  logic [FW-1:0] f_stop_i,
    input  logic [FW-1:0] f_incr_i,
    input  logic [DW-1:0] dwell_i,
    input  logic          wrap_i,
    output logic [FW-1:0] freq_step_o,
    output logic          freq_vld_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] DWELL = 3'd2;
    localparam logic [2:0] ALIGN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]    state;
    logic [2:0]    start_sync;
    logic          start_evt;
    logic [FW-1:0] f_start_r, f_stop_r, f_incr_r;
    logic [DW-1:0] dwell_r, cnt;
    logic [FW:0]   sum_up;
    logic [FW-1:0] next_up, next_f;
    logic          apply, cfg_bad, at_end;

    // Extra sum bit lets an overflowing step saturate to f_stop instead of wrapping.
    assign sum_up  = {1'b0, freq_step_o} + {1'b0, f_incr_r};
    assign next_up = (sum_up > {1'b0, f_stop_r}) ? f_stop_r : sum_up[FW-1:0];

`ifdef NCO_SWEEP_BIDIR_EN
    logic          dir_dn;
    logic [FW-1:0] next_dn;
    assign next_dn = (freq_step_o < f_incr_r || freq_step_o - f_incr_r < f_start_r) ? f_start_r : freq_step_o - f_incr_r;
    assign next_f  = dir_dn ? next_dn : next_up;
    assign at_end  = 1'b0;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            dir_dn <= 1'b0;
        else if (abort_i || state == LOAD)
            dir_dn <= 1'b0;
        else if (state == DWELL && cnt == '0)
            dir_dn <= dir_dn ? (freq_step_o != f_start_r) : (freq_step_o == f_stop_r);
    end
`else
    assign next_f = next_up;
    assign at_end = freq_step_o == f_stop_r;
`endif

    // A zero tuning word never wraps the phase, so waiting for wrap_i would stall forever.
    assign apply   = (ALIGN_WRAP == 0) || wrap_i || (freq_step_o == '0);
    assign cfg_bad = (f_incr_i == '0) || (f_start_i > f_stop_i);
    assign busy_o  = (state == LOAD) || (state == DWELL) || (state == ALIGN);
    assign done_o  = state == DONE;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            start_sync  <= '0;
            start_evt   <= 1'b0;
            f_start_r   <= '0;
            f_stop_r    <= '0;
            f_incr_r    <= '0;
            dwell_r     <= '0;
            cnt         <= '0;
            freq_step_o <= '0;
            freq_vld_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            start_sync <= {start_sync[1:0], start_i};
            start_evt  <= start_sync[1] & ~start_sync[2];
            freq_vld_o <= 1'b0;
            if (abort_i) begin
                state       <= IDLE;
                freq_step_o <= '0;
                freq_vld_o  <= |freq_step_o;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start_evt) begin
                            f_start_r <= f_start_i;
                            f_stop_r  <= f_stop_i;
                            f_incr_r  <= f_incr_i;
                            dwell_r   <= dwell_i;
                            err_o     <= cfg_bad;
                            state     <= cfg_bad ? IDLE : LOAD;
                        end
                    end
                    LOAD: begin
                        freq_step_o <= f_start_r;
                        freq_vld_o  <= 1'b1;
                        cnt         <= dwell_r;
                        state       <= DWELL;
                    end
                    DWELL: begin
                        if (cnt != '0)
                            cnt <= cnt - DW'(1);
                        else
                            state <= at_end ? DONE : ALIGN;
                    end
                    ALIGN: begin
                        if (apply) begin
                            freq_step_o <= next_f;
                            freq_vld_o  <= 1'b1;
                            cnt         <= dwell_r;
                            state       <= DWELL;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: immediate (ALIGN_WRAP=0) and wrap-aligned (ALIGN_WRAP=1) instances share stimulus
// and are compared every cycle against a tone-timeline model.
`timescale 1ns/1ps
module tb_nco_sweep_ctrl;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start_i = 1'b0, abort_i = 1'b0, wrap_i = 1'b0;
    logic [31:0] f_start_i = '0, f_stop_i = '0, f_incr_i = '0;
    logic [15:0] dwell_i = '0;
    logic [31:0] freq_step [2];
    logic        freq_vld [2], busy [2], done [2], err [2];
    int          checks = 0, errors = 0, cyc = 0;
    logic [31:0] seen_v[$];
    int          seen_t[$];

    int          m_mode [2];
    int          m_age [2], m_dwell [2];
    logic [31:0] m_tone [2], m_lo [2], m_hi [2], m_inc [2];
    logic        m_vld [2], m_err [2], m_dn [2];
    logic        hist [4];

    always #5 sys_clk = ~sys_clk;

    nco_sweep_ctrl #(.FW(32), .DW(16), .ALIGN_WRAP(0)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start_i(start_i), .abort_i(abort_i),
        .f_start_i(f_start_i), .f_stop_i(f_stop_i), .f_incr_i(f_incr_i), .dwell_i(dwell_i),
        .wrap_i(wrap_i), .freq_step_o(freq_step[0]), .freq_vld_o(freq_vld[0]),
        .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0])
    );

    nco_sweep_ctrl #(.FW(32), .DW(16), .ALIGN_WRAP(1)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start_i(start_i), .abort_i(abort_i),
        .f_start_i(f_start_i), .f_stop_i(f_stop_i), .f_incr_i(f_incr_i), .dwell_i(dwell_i),
        .wrap_i(wrap_i), .freq_step_o(freq_step[1]), .freq_vld_o(freq_vld[1]),
        .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_age[i] = 0; m_dwell[i] = 0;
            m_tone[i] = '0; m_lo[i] = '0; m_hi[i] = '0; m_inc[i] = '0;
            m_vld[i] = 1'b0; m_err[i] = 1'b0; m_dn[i] = 1'b0;
        end
        for (int k = 0; k < 4; k++) hist[k] = 1'b0;
    endtask

    // Modes: 0 idle, 1 start accepted (first tone next cycle), 2 sweeping, 3 done.
    // m_age counts cycles since the current tone was applied; past dwell the model waits to step.
    task automatic model_step();
        logic   evt;
        longint t;
        evt = hist[2] & ~hist[3];
        for (int i = 0; i < 2; i++) begin
            m_vld[i] = 1'b0;
            if (abort_i) begin
                m_vld[i] = m_tone[i] != 0;
                m_tone[i] = '0; m_mode[i] = 0; m_dn[i] = 1'b0;
            end else if (m_mode[i] == 0 || m_mode[i] == 3) begin
                if (evt) begin
                    m_lo[i] = f_start_i; m_hi[i] = f_stop_i; m_inc[i] = f_incr_i; m_dwell[i] = int'(dwell_i);
                    m_err[i] = (f_incr_i == 0) || (f_start_i > f_stop_i);
                    m_mode[i] = m_err[i] ? 0 : 1;
                end
            end else if (m_mode[i] == 1) begin
                m_tone[i] = m_lo[i]; m_vld[i] = 1'b1; m_age[i] = 0; m_mode[i] = 2; m_dn[i] = 1'b0;
            end else if (m_age[i] < m_dwell[i]) begin
                m_age[i]++;
            end else if (m_age[i] == m_dwell[i]) begin
`ifdef NCO_SWEEP_BIDIR_EN
                if (m_tone[i] == (m_dn[i] ? m_lo[i] : m_hi[i])) m_dn[i] = ~m_dn[i];
                m_age[i]++;
`else
                if (m_tone[i] == m_hi[i]) m_mode[i] = 3; else m_age[i]++;
`endif
            end else if (i == 0 || wrap_i || m_tone[i] == 0) begin
                if (m_dn[i]) begin
                    t = longint'(m_tone[i]) - longint'(m_inc[i]);
                    m_tone[i] = (t < longint'(m_lo[i])) ? m_lo[i] : t[31:0];
                end else begin
                    t = longint'(m_tone[i]) + longint'(m_inc[i]);
                    m_tone[i] = (t > longint'(m_hi[i])) ? m_hi[i] : t[31:0];
                end
                m_vld[i] = 1'b1; m_age[i] = 0;
            end
        end
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = start_i;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) model_reset(); else model_step();
        end
    end

    initial forever begin
        @(negedge sys_clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d freq_step", i), freq_step[i], m_tone[i]);
            chk($sformatf("dut%0d freq_vld", i), 32'(freq_vld[i]), 32'(m_vld[i]));
            chk($sformatf("dut%0d busy", i), 32'(busy[i]), 32'(m_mode[i] == 1 || m_mode[i] == 2));
            chk($sformatf("dut%0d done", i), 32'(done[i]), 32'(m_mode[i] == 3));
            chk($sformatf("dut%0d err", i), 32'(err[i]), 32'(m_err[i]));
        end
        if (freq_vld[0]) begin
            seen_v.push_back(freq_step[0]);
            seen_t.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc, input logic [15:0] d);
        f_start_i = s; f_stop_i = e; f_incr_i = inc; dwell_i = d;
    endtask

    task automatic clear_seen();
        seen_v.delete();
        seen_t.delete();
    endtask

    // Leaves the bench just after the edge at which the start event is accepted.
    task automatic pulse_start();
        start_i = 1'b1;
        repeat (3) tick();
        start_i = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int i, input int lim);
        int n = 0;
        while (!done[i] && n < lim) begin tick(); n++; end
        chk($sformatf("dut%0d reaches done", i), 32'(done[i]), 1);
    endtask

    task automatic wait_val(input int i, input logic [31:0] v, input int lim);
        int n = 0;
        while (freq_step[i] !== v && n < lim) begin tick(); n++; end
        chk($sformatf("dut%0d reaches tone", i), freq_step[i], v);
    endtask

`ifdef NCO_SWEEP_BIDIR_EN
    logic [31:0] tri_exp [8] = '{32'd1, 32'd2, 32'd3, 32'd2, 32'd1, 32'd2, 32'd3, 32'd2};
`endif

    initial begin
        int n;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        tick();
        chk("reset freq_step", freq_step[0], 0);
        chk("reset busy", 32'(busy[0]), 0);
        chk("reset done", 32'(done[0]), 0);
`ifndef NCO_SWEEP_BIDIR_EN
        // Basic sweep with start latency; the aligned instance stalls in ALIGN with wrap_i low.
        set_cfg(32'h100, 32'h400, 32'h100, 16'd3);
        clear_seen();
        start_i = 1'b1;
        repeat (4) tick();
        chk("latency before N+4", freq_step[0], 0);
        tick();
        chk("latency at N+4", freq_step[0], 32'h100);
        chk("first vld", 32'(freq_vld[0]), 1);
        start_i = 1'b0;
        wait_done(0, 60);
        chk("basic tone count", seen_v.size(), 4);
        for (int k = 0; k < seen_v.size() && k < 4; k++) chk("basic tone value", seen_v[k], 32'h100 * (k + 1));
        for (int k = 1; k < seen_t.size(); k++) chk("basic tone spacing", seen_t[k] - seen_t[k-1], 5);
        chk("basic final tone", freq_step[0], 32'h400);
        repeat (50) tick();
        chk("align hold tone", freq_step[1], 32'h100);
        chk("align hold busy", 32'(busy[1]), 1);
        wrap_i = 1'b1;
        tick();
        chk("wrap apply tone", freq_step[1], 32'h200);
        chk("wrap apply vld", 32'(freq_vld[1]), 1);
        wait_done(1, 100);
        // Saturation at the top of the tuning range.
        set_cfg(32'hFFFFFF00, 32'hFFFFFFFF, 32'h200, 16'd2);
        clear_seen();
        pulse_start();
        wait_done(0, 40);
        wait_done(1, 40);
        chk("sat tone count", seen_v.size(), 2);
        if (seen_v.size() == 2) chk("sat second tone", seen_v[1], 32'hFFFFFFFF);
        // Zero first tone steps without any wrap, then abort.
        wrap_i = 1'b0;
        set_cfg(32'h0, 32'h20, 32'h10, 16'd1);
        clear_seen();
        pulse_start();
        wait_done(0, 40);
        repeat (5) tick();
        chk("zero start tone count", seen_v.size(), 3);
        chk("zero start step", freq_step[1], 32'h10);
        chk("zero start stalls", 32'(busy[1]), 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort tone", freq_step[1], 0);
        chk("abort vld", 32'(freq_vld[1]), 1);
        chk("abort busy", 32'(busy[1]), 0);
        chk("abort clears done", 32'(done[0]), 0);
        // Bad configurations, recovery, and an ignored mid-sweep start.
        set_cfg(32'h10, 32'h30, 32'h0, 16'd4);
        pulse_start();
        repeat (3) tick();
        chk("zero incr err", 32'(err[0]), 1);
        chk("zero incr busy", 32'(busy[0]), 0);
        chk("zero incr tone", freq_step[0], 0);
        set_cfg(32'h40, 32'h30, 32'h10, 16'd4);
        pulse_start();
        repeat (3) tick();
        chk("start above stop err", 32'(err[0]), 1);
        wrap_i = 1'b1;
        set_cfg(32'h10, 32'h30, 32'h10, 16'd5);
        clear_seen();
        pulse_start();
        chk("valid start clears err", 32'(err[0]), 0);
        wait_val(0, 32'h20, 30);
        pulse_start();
        wait_done(0, 60);
        chk("restart ignored count", seen_v.size(), 3);
        for (int k = 0; k < seen_v.size() && k < 3; k++) chk("restart ignored value", seen_v[k], 32'h10 * (k + 1));
        // Abort coinciding with a start event, in DWELL and in IDLE.
        set_cfg(32'h40, 32'h80, 32'h40, 16'd20);
        pulse_start();
        wait_val(0, 32'h40, 10);
        start_i = 1'b1;
        repeat (3) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("dwell abort tone", freq_step[0], 0);
        chk("dwell abort vld", 32'(freq_vld[0]), 1);
        chk("dwell abort busy", 32'(busy[0]), 0);
        repeat (6) tick();
        chk("dwell abort no restart", 32'(busy[0]), 0);
        start_i = 1'b1;
        repeat (3) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        repeat (6) tick();
        chk("idle abort beats start", 32'(busy[0]), 0);
        // Asynchronous reset while the aligned instance waits in ALIGN.
        wrap_i = 1'b0;
        set_cfg(32'h100, 32'h400, 32'h100, 16'd2);
        pulse_start();
        repeat (12) tick();
        chk("pre-reset busy", 32'(busy[1]), 1);
        chk("pre-reset tone", freq_step[1], 32'h100);
        sys_rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d async reset tone", i), freq_step[i], 0);
            chk($sformatf("dut%0d async reset vld", i), 32'(freq_vld[i]), 0);
            chk($sformatf("dut%0d async reset busy", i), 32'(busy[i]), 0);
            chk($sformatf("dut%0d async reset done", i), 32'(done[i]), 0);
            chk($sformatf("dut%0d async reset err", i), 32'(err[i]), 0);
        end
        repeat (2) tick();
        sys_rst_n = 1'b1;
        repeat (3) tick();
`else
        // Triangle sweep never finishes.
        wrap_i = 1'b1;
        set_cfg(32'd1, 32'd3, 32'd1, 16'd0);
        clear_seen();
        pulse_start();
        n = 0;
        while (seen_v.size() < 8 && n < 60) begin tick(); n++; end
        chk("bidir tone count", 32'(seen_v.size() >= 8), 1);
        for (int k = 0; k < seen_v.size() && k < 8; k++) chk("bidir tone value", seen_v[k], tri_exp[k]);
        chk("bidir never done", 32'(done[0]), 0);
        chk("bidir still busy", 32'(busy[0]), 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("bidir abort busy", 32'(busy[0]), 0);
        repeat (3) tick();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
